mac_array_2x2: RTL and testbench
================================

# mac_array_2x2

Four independent signed multiply-accumulate lanes arranged as a 2x2 array. Each cycle, every lane (i,j) can add the product a[i][j]*b[i][j] to its own 32-bit accumulator. This is element-wise accumulation, not a matrix product. The block is the compute core of the matrix accelerator; the AXI front-end drives operands and control and reads back acc.

## Interface
Parameters:
- DATA_W, default 8: signed operand width.
- ACC_W, default 32: signed accumulator width. Must be at least 2*DATA_W.

Ports (clock and reset first):
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst_n, input, 1: reset, synchronous and active-low.
- en, input, 1: accumulate enable, applied to all four lanes.
- clear, input, 1: synchronous zeroing of all accumulators.
- a, input, signed [DATA_W-1:0] [2][2]: operand A, one value per lane.
- b, input, signed [DATA_W-1:0] [2][2]: operand B, one value per lane.
- acc, output, signed [ACC_W-1:0] [2][2]: registered accumulators, one per lane.

## Operation
- Each lane (i,j) for i,j in {0,1} operates independently with the same control.
- The per-lane update is decided at each rising clk edge, in this priority order:
  - rst_n==0: acc[i][j] <= 0.
  - else clear==1: acc[i][j] <= 0. clear overrides en; the product is discarded in that cycle.
  - else en==1: acc[i][j] <= acc[i][j] + sext(a[i][j]*b[i][j]).
  - else: acc holds its value.
- Arithmetic rules:
  - Signed two's-complement throughout.
  - The product is full precision (2*DATA_W bits) and sign-extended to ACC_W.
  - The add wraps modulo 2^ACC_W. There is no saturation and no overflow flag.
- Operands are sampled combinationally at the edge. They are not registered inside the block and need to be held only around the enabling edge.
- There is no handshake. en and clear are level signals evaluated every cycle.

## Timing
- Reset value: acc = 0 for all four lanes. Reset is synchronous, so acc clears on the first rising edge with rst_n low and stays 0 while rst_n is low.
- Reset asserted mid-accumulation zeroes all lanes at the next edge, regardless of en and clear.
- Latency is 1 cycle. acc reflects an enabled product after the rising edge that sampled en=1, and is stable for the whole following cycle.
- Throughput is one MAC per lane per cycle. Holding en high for N edges accumulates N products.
- clear and en asserted together: result is 0, not the product.
- Combinational path per lane: one DATA_W x DATA_W multiply feeding one ACC_W adder. There is no pipelining, so the block must close timing at the accelerator clock as a single stage.

## Structure
- Package mac_pkg holds:
  - localparams DATA_W=8 and ACC_W=32.
  - typedef operand_t, signed [DATA_W-1:0].
  - typedef acc_t, signed [ACC_W-1:0].
  - array typedefs for the 2x2 operand and accumulator arrays.
- Sub-module mac_pe implements one lane: clk, rst_n, en, clear, a, b, acc. Its logic is the multiplier, the sign-extend, the adder, and the priority register.
- mac_array_2x2 instantiates four mac_pe with a generate loop over i and j, and wires the shared control to each.

## Test plan
- Reset: hold rst_n=0 for two edges with arbitrary en, a and b -> acc = {0,0,0,0}.
- Single accumulate:
  - Stimulus: a={1,3,5,7}, b={2,4,6,8}, en=1 for exactly one edge from zero.
  - Response: acc = {2,12,30,56}.
- Clear then reaccumulate:
  - clear=1, en=0 for one edge -> all 0.
  - Then a=b=2 in every lane, en=1 for one edge -> acc = {4,4,4,4}.
  - Hold en=1 for three edges total -> {12,12,12,12}.
  - Drop en -> values hold.
- Signed and priority:
  - a=-128, b=-128, en=1 for one edge -> 16384. Then a=-128, b=127 for one edge -> 16384-16256 = 128.
  - clear=1 together with en=1 -> 0.
- Wrap-around:
  - Preload near 2^31-1 by repeated en with a=b=127 (16129 per edge), then cross the limit.
  - Required: the value wraps to negative, matching a modulo-2^32 reference model.
  - Apply rst_n=0 mid-run -> 0 next edge.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and types for the 2x2 element-wise MAC core.
package mac_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;

  typedef logic signed [DATA_W-1:0] operand_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef operand_t operand_arr_t [2][2];
  typedef acc_t     acc_arr_t     [2][2];

endpackage

// File: rtl/mac_pe.sv
// One signed MAC lane: full-precision product, sign-extend, wrapping add,
// and a reset/clear/enable priority register.
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  acc_next_s;
  logic signed [ACC_W-1:0]  acc_r;

  // Product is widened on both operands first so the multiply is exact.
  always_comb begin
    prod_s     = PROD_W'(a) * PROD_W'(b);
    prod_ext_s = ACC_W'(prod_s);
  end

  // Next accumulator value: clear beats enable, otherwise hold.
  always_comb begin
    acc_next_s = acc_r;
    if (clear) begin
      acc_next_s = '0;
    end else if (en) begin
      acc_next_s = acc_r + prod_ext_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else begin
      acc_r <= acc_next_s;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/mac_array_2x2.sv
// Compute core: four independent MAC lanes sharing en/clear/reset,
// accumulating a[i][j]*b[i][j] element-wise.
module mac_array_2x2
  import mac_pkg::*;
#(
  parameter int DATA_W = mac_pkg::DATA_W,
  parameter int ACC_W  = mac_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] a   [2][2],
  input  logic signed [DATA_W-1:0] b   [2][2],
  output logic signed [ACC_W-1:0]  acc [2][2]
);

  for (genvar gi = 0; gi < 2; gi++) begin : g_row
    for (genvar gj = 0; gj < 2; gj++) begin : g_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clear (clear),
        .a     (a[gi][gj]),
        .b     (b[gi][gj]),
        .acc   (acc[gi][gj])
      );
    end
  end

endmodule

// File: tb/tb_mac_array_2x2.sv
// Bench for mac_array_2x2: table-driven vectors with constant expectations,
// plus a narrow-accumulator instance to exercise modulo wrap-around.
module tb_mac_array_2x2;
  import mac_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, en, clear;
  operand_arr_t a, b;
  acc_arr_t     acc;
  logic signed [15:0] acc_n [2][2];

  mac_array_2x2 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .acc(acc)
  );

  // Same operands and control, 16-bit accumulators so wrap is reachable quickly.
  mac_array_2x2 #(.DATA_W(8), .ACC_W(16)) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .a(a), .b(b), .acc(acc_n)
  );

  typedef struct {
    bit rst_n;
    bit en;
    bit clear;
    int a  [4];
    int b  [4];
    int ex [4];
  } vec_t;

  typedef struct {
    int w [4];
    int n [4];
  } exp_t;

  exp_t sb [$];
  int   model_w [4];
  int   model_n [4];
  int   nvec = 0;
  int   nerr = 0;
  vec_t vecs [13];

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic apply(input bit r, input bit e, input bit c,
                       input int av [4], input int bv [4],
                       input bit use_tab, input int tab [4], input string name);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    clear = c;
    for (int k = 0; k < 4; k++) begin
      a[k/2][k%2] = operand_t'(av[k]);
      b[k/2][k%2] = operand_t'(bv[k]);
      if (!r || c) begin
        model_w[k] = 0;
        model_n[k] = 0;
      end else if (e) begin
        model_w[k] = model_w[k] + av[k] * bv[k];
        model_n[k] = wrap16(model_n[k] + av[k] * bv[k]);
      end
      x.w[k] = use_tab ? tab[k] : model_w[k];
      x.n[k] = model_n[k];
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (acc[k/2][k%2] !== x.w[k]) begin
        nerr++;
        $display("FAIL %s lane%0d acc: got %0d expected %0d", name, k, acc[k/2][k%2], x.w[k]);
      end
      nvec++;
      if (int'(acc_n[k/2][k%2]) !== x.n[k]) begin
        nerr++;
        $display("FAIL %s lane%0d acc16: got %0d expected %0d", name, k, acc_n[k/2][k%2], x.n[k]);
      end
    end
  endtask

  initial begin
    int s2 [4];
    int s127 [4];
    int z [4];
    s2   = '{2, 2, 2, 2};
    s127 = '{127, 127, 127, 127};
    z    = '{0, 0, 0, 0};

    vecs[0]  = '{rst_n:1'b0, en:1'b1, clear:1'b0, a:'{5, -7, 100, 3},   b:'{9, 11, -4, 8},  ex:'{0, 0, 0, 0}};
    vecs[1]  = '{rst_n:1'b0, en:1'b1, clear:1'b1, a:'{-1, 2, 3, 4},     b:'{6, 6, 6, 6},    ex:'{0, 0, 0, 0}};
    vecs[2]  = '{rst_n:1'b1, en:1'b1, clear:1'b0, a:'{1, 3, 5, 7},      b:'{2, 4, 6, 8},    ex:'{2, 12, 30, 56}};
    vecs[3]  = '{rst_n:1'b1, en:1'b0, clear:1'b1, a:'{1, 3, 5, 7},      b:'{2, 4, 6, 8},    ex:'{0, 0, 0, 0}};
    vecs[4]  = '{rst_n:1'b1, en:1'b1, clear:1'b0, a:'{2, 2, 2, 2},      b:'{2, 2, 2, 2},    ex:'{4, 4, 4, 4}};
    vecs[5]  = '{rst_n:1'b1, en:1'b1, clear:1'b0, a:'{2, 2, 2, 2},      b:'{2, 2, 2, 2},    ex:'{8, 8, 8, 8}};
    vecs[6]  = '{rst_n:1'b1, en:1'b1, clear:1'b0, a:'{2, 2, 2, 2},      b:'{2, 2, 2, 2},    ex:'{12, 12, 12, 12}};
    vecs[7]  = '{rst_n:1'b1, en:1'b0, clear:1'b0, a:'{2, 2, 2, 2},      b:'{2, 2, 2, 2},    ex:'{12, 12, 12, 12}};
    vecs[8]  = '{rst_n:1'b1, en:1'b0, clear:1'b0, a:'{99, -5, 17, 1},   b:'{-3, 7, 9, 1},   ex:'{12, 12, 12, 12}};
    vecs[9]  = '{rst_n:1'b1, en:1'b0, clear:1'b1, a:'{0, 0, 0, 0},      b:'{0, 0, 0, 0},    ex:'{0, 0, 0, 0}};
    vecs[10] = '{rst_n:1'b1, en:1'b1, clear:1'b0, a:'{-128, -128, -128, -128}, b:'{-128, -128, -128, -128}, ex:'{16384, 16384, 16384, 16384}};
    vecs[11] = '{rst_n:1'b1, en:1'b1, clear:1'b0, a:'{-128, -128, -128, -128}, b:'{127, 127, 127, 127},     ex:'{128, 128, 128, 128}};
    vecs[12] = '{rst_n:1'b1, en:1'b1, clear:1'b1, a:'{5, -9, 77, 12},   b:'{5, 3, 2, -11},  ex:'{0, 0, 0, 0}};

    for (int v = 0; v < 13; v++) begin
      apply(vecs[v].rst_n, vecs[v].en, vecs[v].clear, vecs[v].a, vecs[v].b,
            1'b1, vecs[v].ex, $sformatf("vec%0d", v));
    end

    // Wrap-around: 16-bit lanes overflow on the third 127*127 product.
    apply(1'b1, 1'b0, 1'b1, z, z, 1'b1, '{0, 0, 0, 0}, "wrap_clear");
    apply(1'b1, 1'b1, 1'b0, s127, s127, 1'b1, '{16129, 16129, 16129, 16129}, "wrap_1");
    apply(1'b1, 1'b1, 1'b0, s127, s127, 1'b1, '{32258, 32258, 32258, 32258}, "wrap_2");
    apply(1'b1, 1'b1, 1'b0, s127, s127, 1'b1, '{48387, 48387, 48387, 48387}, "wrap_3");
    nvec++;
    if (acc_n[0][0] !== -16'sd17149) begin
      nerr++;
      $display("FAIL wrap16_neg: got %0d expected -17149", acc_n[0][0]);
    end
    for (int k = 0; k < 6; k++) begin
      apply(1'b1, 1'b1, 1'b0, s127, s127, 1'b0, z, $sformatf("wrap_run%0d", k));
    end
    apply(1'b1, 1'b1, 1'b0, s2, s2, 1'b0, z, "pre_reset");
    apply(1'b0, 1'b1, 1'b0, s127, s127, 1'b1, '{0, 0, 0, 0}, "mid_reset");
    apply(1'b0, 1'b1, 1'b0, s127, s127, 1'b1, '{0, 0, 0, 0}, "reset_hold");
    apply(1'b1, 1'b1, 1'b0, '{-3, 4, -5, 6}, '{7, -8, -9, 10}, 1'b1, '{-21, -32, 45, 60}, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
